// File: rtl/axi_pkg.sv
// Shared AXI definitions: bus widths (mirroring AXI_define.svh), response
// codes and the default-slave state encoding.
package axi_pkg;

    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_DATA_BITS = 32;
    localparam int AXI_LEN_BITS  = 8;
    localparam int AXI_STRB_BITS = 4;

    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } ds_state_t;

endpackage

// File: rtl/default_slave.sv
// AXI4 decode-error slave: answers unmapped reads/writes with DECERR, one at a time.
// Optional DEFAULT_SLAVE_LEN_CHECK_EN ends writes on the AWLEN count instead of WLAST.
module default_slave
    import axi_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,

    input  logic [AXI_IDS_BITS-1:0]  ARID_default,
    input  logic [AXI_LEN_BITS-1:0]  ARLEN_default,
    input  logic                     ARVALID_default,
    output logic                     ARREADY_default,

    output logic [AXI_IDS_BITS-1:0]  RID_default,
    output logic [AXI_DATA_BITS-1:0] RDATA_default,
    output logic [1:0]               RRESP_default,
    output logic                     RLAST_default,
    output logic                     RVALID_default,
    input  logic                     RREADY_default,

    input  logic [AXI_IDS_BITS-1:0]  AWID_default,
    input  logic [AXI_LEN_BITS-1:0]  AWLEN_default,
    input  logic                     AWVALID_default,
    output logic                     AWREADY_default,

    input  logic [AXI_DATA_BITS-1:0] WDATA_default,
    input  logic [AXI_STRB_BITS-1:0] WSTRB_default,
    input  logic                     WLAST_default,
    input  logic                     WVALID_default,
    output logic                     WREADY_default,

    output logic [AXI_IDS_BITS-1:0]  BID_default,
    output logic [1:0]               BRESP_default,
    output logic                     BVALID_default,
    input  logic                     BREADY_default
);

    ds_state_t               state_q, state_d;
    logic [AXI_LEN_BITS-1:0] cnt_q,   cnt_d;
    logic [AXI_LEN_BITS-1:0] len_q,   len_d;
    logic [AXI_IDS_BITS-1:0] id_q,    id_d;

    logic lastBeat;
    logic unusedW;

    assign lastBeat = (cnt_q == len_q);
    assign unusedW  = ^{WDATA_default, WSTRB_default, WLAST_default};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                // AW wins a tie: ARREADY is already low whenever AWVALID is high
                if (AWVALID_default) begin
                    id_d    = AWID_default;
                    len_d   = AWLEN_default;
                    cnt_d   = '0;
                    state_d = WRITE;
                end else if (ARVALID_default) begin
                    id_d    = ARID_default;
                    len_d   = ARLEN_default;
                    cnt_d   = '0;
                    state_d = READ;
                end
            end
            READ: begin
                if (RREADY_default) begin
                    cnt_d = cnt_q + 1'b1;
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            WRITE: begin
                if (WVALID_default) begin
`ifdef DEFAULT_SLAVE_LEN_CHECK_EN
                    cnt_d = cnt_q + 1'b1;
                    if (lastBeat) begin
                        state_d = RESP;
                    end
`else
                    if (WLAST_default) begin
                        state_d = RESP;
                    end
`endif
                end
            end
            RESP: begin
                if (BREADY_default) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        AWREADY_default = (state_q == IDLE);
        ARREADY_default = (state_q == IDLE) && !AWVALID_default;
        RVALID_default  = (state_q == READ);
        RLAST_default   = (state_q == READ) && lastBeat;
        RID_default     = (state_q == READ) ? id_q : '0;
        RDATA_default   = '0;
        RRESP_default   = AXI_RESP_DECERR;
        WREADY_default  = (state_q == WRITE);
        BVALID_default  = (state_q == RESP);
        BID_default     = (state_q == RESP) ? id_q : '0;
        BRESP_default   = AXI_RESP_DECERR;
    end

endmodule

// File: tb/tb_default_slave.sv
// Directed self-checking bench for default_slave; covers both settings of
// DEFAULT_SLAVE_LEN_CHECK_EN in the write-length step.
module tb_default_slave;
    import axi_pkg::*;

    logic                     clk;
    logic                     rst;
    logic [AXI_IDS_BITS-1:0]  ARID_default;
    logic [AXI_LEN_BITS-1:0]  ARLEN_default;
    logic                     ARVALID_default;
    logic                     ARREADY_default;
    logic [AXI_IDS_BITS-1:0]  RID_default;
    logic [AXI_DATA_BITS-1:0] RDATA_default;
    logic [1:0]               RRESP_default;
    logic                     RLAST_default;
    logic                     RVALID_default;
    logic                     RREADY_default;
    logic [AXI_IDS_BITS-1:0]  AWID_default;
    logic [AXI_LEN_BITS-1:0]  AWLEN_default;
    logic                     AWVALID_default;
    logic                     AWREADY_default;
    logic [AXI_DATA_BITS-1:0] WDATA_default;
    logic [AXI_STRB_BITS-1:0] WSTRB_default;
    logic                     WLAST_default;
    logic                     WVALID_default;
    logic                     WREADY_default;
    logic [AXI_IDS_BITS-1:0]  BID_default;
    logic [1:0]               BRESP_default;
    logic                     BVALID_default;
    logic                     BREADY_default;

    int checks   = 0;
    int failures = 0;

    default_slave dut (
        .clk             (clk),
        .rst             (rst),
        .ARID_default    (ARID_default),
        .ARLEN_default   (ARLEN_default),
        .ARVALID_default (ARVALID_default),
        .ARREADY_default (ARREADY_default),
        .RID_default     (RID_default),
        .RDATA_default   (RDATA_default),
        .RRESP_default   (RRESP_default),
        .RLAST_default   (RLAST_default),
        .RVALID_default  (RVALID_default),
        .RREADY_default  (RREADY_default),
        .AWID_default    (AWID_default),
        .AWLEN_default   (AWLEN_default),
        .AWVALID_default (AWVALID_default),
        .AWREADY_default (AWREADY_default),
        .WDATA_default   (WDATA_default),
        .WSTRB_default   (WSTRB_default),
        .WLAST_default   (WLAST_default),
        .WVALID_default  (WVALID_default),
        .WREADY_default  (WREADY_default),
        .BID_default     (BID_default),
        .BRESP_default   (BRESP_default),
        .BVALID_default  (BVALID_default),
        .BREADY_default  (BREADY_default)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and land just after the edge, away from it.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  beats;
        int  cyc;
        logic stalled;
        logic heldLast;
        logic [AXI_IDS_BITS-1:0] heldId;

        rst = 1'b0;
        ARID_default = '0; ARLEN_default = '0; ARVALID_default = 1'b0;
        RREADY_default = 1'b0;
        AWID_default = '0; AWLEN_default = '0; AWVALID_default = 1'b0;
        WDATA_default = 32'hDEADBEEF; WSTRB_default = 4'hF;
        WLAST_default = 1'b0; WVALID_default = 1'b0;
        BREADY_default = 1'b0;

        // Reset state
        #1;
        checkOutput("rst_awready", AWREADY_default, 1);
        checkOutput("rst_arready", ARREADY_default, 1);
        checkOutput("rst_rvalid",  RVALID_default,  0);
        checkOutput("rst_rlast",   RLAST_default,   0);
        checkOutput("rst_wready",  WREADY_default,  0);
        checkOutput("rst_bvalid",  BVALID_default,  0);
        checkOutput("rst_rid",     RID_default,     0);
        checkOutput("rst_bid",     BID_default,     0);
        AWVALID_default = 1'b1;
        #1;
        checkOutput("rst_arready_awvalid", ARREADY_default, 0);
        AWVALID_default = 1'b0;
        applyStimulus();
        applyStimulus();
        rst = 1'b1;
        applyStimulus();

        // Single-beat read
        ARID_default = 8'h12; ARLEN_default = 8'd0; ARVALID_default = 1'b1; RREADY_default = 1'b1;
        applyStimulus();
        ARVALID_default = 1'b0;
        checkOutput("r1_rvalid",  RVALID_default,  1);
        checkOutput("r1_rlast",   RLAST_default,   1);
        checkOutput("r1_rid",     RID_default,     8'h12);
        checkOutput("r1_rdata",   RDATA_default,   0);
        checkOutput("r1_rresp",   RRESP_default,   2'b11);
        checkOutput("r1_arready", ARREADY_default, 0);
        applyStimulus();
        checkOutput("r1_rvalid_done",  RVALID_default,  0);
        checkOutput("r1_arready_again", ARREADY_default, 1);

        // 4-beat read with RREADY toggling 1,0,1,0,...
        ARID_default = 8'h34; ARLEN_default = 8'd3; ARVALID_default = 1'b1; RREADY_default = 1'b0;
        applyStimulus();
        ARVALID_default = 1'b0;
        beats = 0; stalled = 1'b0; heldLast = 1'b0; heldId = '0; cyc = 0;
        while (cyc < 20) begin
            RREADY_default = (cyc % 2 == 0);
            #1;
            if (!RVALID_default) break;
            if (stalled) begin
                checkOutput("r4_stall_rid",  RID_default,   heldId);
                checkOutput("r4_stall_rlast", RLAST_default, heldLast);
            end
            checkOutput("r4_rlast", RLAST_default, beats == 3);
            checkOutput("r4_rid",   RID_default,   8'h34);
            if (RREADY_default) begin
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                heldId = RID_default;
                heldLast = RLAST_default;
            end
            applyStimulus();
            cyc++;
        end
        checkOutput("r4_beats", beats, 4);
        checkOutput("r4_bound", cyc < 20, 1);

        // AW and AR together: write first, then the pending read
        RREADY_default = 1'b1;
        AWID_default = 8'h21; AWLEN_default = 8'd1; AWVALID_default = 1'b1;
        ARID_default = 8'h35; ARLEN_default = 8'd0; ARVALID_default = 1'b1;
        #1;
        checkOutput("aw_ar_awready", AWREADY_default, 1);
        checkOutput("aw_ar_arready", ARREADY_default, 0);
        applyStimulus();
        AWVALID_default = 1'b0;
        checkOutput("w_wready",    WREADY_default,  1);
        checkOutput("w_arready",   ARREADY_default, 0);
        WVALID_default = 1'b1; WLAST_default = 1'b0;
        applyStimulus();
        checkOutput("w_beat1_bvalid", BVALID_default, 0);
        WLAST_default = 1'b1;
        applyStimulus();
        WVALID_default = 1'b0; WLAST_default = 1'b0;
        checkOutput("b_bvalid", BVALID_default, 1);
        checkOutput("b_bid",    BID_default,    8'h21);
        checkOutput("b_bresp",  BRESP_default,  2'b11);
        checkOutput("b_wready", WREADY_default, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("b_stall_bvalid", BVALID_default, 1);
            checkOutput("b_stall_bid",    BID_default,    8'h21);
        end
        BREADY_default = 1'b1;
        applyStimulus();
        BREADY_default = 1'b0;
        checkOutput("b_done_bvalid",  BVALID_default,  0);
        checkOutput("b_idle_arready", ARREADY_default, 1);
        applyStimulus();
        ARVALID_default = 1'b0;
        checkOutput("pend_rvalid", RVALID_default, 1);
        checkOutput("pend_rid",    RID_default,    8'h35);
        checkOutput("pend_rlast",  RLAST_default,  1);
        applyStimulus();
        checkOutput("pend_done", RVALID_default, 0);

        // AWLEN=1 with WLAST only on a third beat
        AWID_default = 8'h3A; AWLEN_default = 8'd1; AWVALID_default = 1'b1;
        applyStimulus();
        AWVALID_default = 1'b0;
        WVALID_default = 1'b1; WLAST_default = 1'b0;
        applyStimulus();
        checkOutput("len_beat1_bvalid", BVALID_default, 0);
        applyStimulus();
`ifdef DEFAULT_SLAVE_LEN_CHECK_EN
        checkOutput("len_beat2_bvalid", BVALID_default, 1);
        checkOutput("len_beat2_bid",    BID_default,    8'h3A);
        checkOutput("len_beat3_wready", WREADY_default, 0);
        WLAST_default = 1'b1;
        applyStimulus();
        checkOutput("len_beat3_bvalid", BVALID_default, 1);
        checkOutput("len_beat3_wready2", WREADY_default, 0);
        WVALID_default = 1'b0; WLAST_default = 1'b0;
`else
        checkOutput("len_beat2_bvalid", BVALID_default, 0);
        checkOutput("len_beat2_wready", WREADY_default, 1);
        WLAST_default = 1'b1;
        applyStimulus();
        WVALID_default = 1'b0; WLAST_default = 1'b0;
        checkOutput("len_beat3_bvalid", BVALID_default, 1);
        checkOutput("len_beat3_bid",    BID_default,    8'h3A);
`endif
        BREADY_default = 1'b1;
        applyStimulus();
        BREADY_default = 1'b0;
        checkOutput("len_b_done", BVALID_default, 0);

        // Maximum length burst: 256 beats, RLAST only on the final one
        ARID_default = 8'h0C; ARLEN_default = 8'hFF; ARVALID_default = 1'b1; RREADY_default = 1'b1;
        applyStimulus();
        ARVALID_default = 1'b0;
        beats = 0; cyc = 0;
        while (RVALID_default && cyc < 300) begin
            if (RLAST_default !== (beats == 255)) begin
                checkOutput("max_rlast", RLAST_default, beats == 255);
            end
            beats++;
            applyStimulus();
            cyc++;
        end
        checkOutput("max_beats", beats, 256);

        // Reset mid-read after the first of four beats
        ARID_default = 8'h2B; ARLEN_default = 8'd3; ARVALID_default = 1'b1; RREADY_default = 1'b1;
        applyStimulus();
        ARVALID_default = 1'b0;
        checkOutput("mid_rvalid", RVALID_default, 1);
        checkOutput("mid_rlast",  RLAST_default,  0);
        applyStimulus();
        checkOutput("mid_beat2_rlast", RLAST_default, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_rvalid",  RVALID_default,  0);
        checkOutput("mid_rst_rlast",   RLAST_default,   0);
        checkOutput("mid_rst_rid",     RID_default,     0);
        checkOutput("mid_rst_bvalid",  BVALID_default,  0);
        checkOutput("mid_rst_wready",  WREADY_default,  0);
        checkOutput("mid_rst_arready", ARREADY_default, 1);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        checkOutput("post_rst_rvalid",  RVALID_default,  0);
        checkOutput("post_rst_arready", ARREADY_default, 1);
        ARID_default = 8'h07; ARLEN_default = 8'd0; ARVALID_default = 1'b1;
        applyStimulus();
        ARVALID_default = 1'b0;
        checkOutput("post_rst_rd_rvalid", RVALID_default, 1);
        checkOutput("post_rst_rd_rid",    RID_default,    8'h07);
        checkOutput("post_rst_rd_rlast",  RLAST_default,  1);
        applyStimulus();
        checkOutput("post_rst_rd_done", RVALID_default, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
